// File: rtl/corelet_ctrl.sv
// Sequences one corelet run: weight fill/load, activation fill/execute, OFIFO readout to pmem, per kernel position.
// Latency: first xmem read one cycle after start; 160 cycles per kernel position unstalled at default sizes.
// Backpressure: l0_full stalls the fill phases in the same cycle; ofifo_valid gates each readout pop combinationally.
module corelet_ctrl #(
    parameter int row     = 8,
    parameter int col     = 8,
    parameter int len_nij = 36,
    parameter int kij     = 9,
    parameter int w_base  = 128,
    parameter int addr_w  = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              l0_full,
    input  logic              ofifo_valid,
    output logic              xmem_cen,
    output logic [addr_w-1:0] xmem_addr,
    output logic              l0_wr,
    output logic              l0_rd,
    output logic              load,
    output logic              execute,
    output logic              ofifo_rd,
    output logic              pmem_wen,
    output logic [addr_w-1:0] pmem_addr,
    output logic              busy,
    output logic              done
);

    localparam int CNT_MAX = (row + col > len_nij + 1) ? row + col : len_nij + 1;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int K_W     = $clog2(kij + 1);
    localparam int NIJ_W   = $clog2(len_nij + 1);

    typedef enum logic [3:0] {
        IDLE, W_FILL, W_LOAD, W_DRAIN, A_FILL, EXEC, E_DRAIN, READOUT, NEXT_K
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [K_W-1:0]     k, k_nxt;
    logic [NIJ_W-1:0]   rd_cnt, wr_cnt;
    logic               pop_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            k      <= '0;
            rd_cnt <= '0;
            wr_cnt <= '0;
            pop_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            k     <= k_nxt;
            pop_q <= ofifo_rd;
            if (state == READOUT) begin
                if (ofifo_rd) rd_cnt <= rd_cnt + NIJ_W'(1);
                if (pop_q)    wr_cnt <= wr_cnt + NIJ_W'(1);
            end else begin
                rd_cnt <= '0;
                wr_cnt <= '0;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + CNT_W'(1);
        k_nxt     = k;
        xmem_cen  = 1'b1;
        xmem_addr = '0;
        l0_wr     = 1'b0;
        l0_rd     = 1'b0;
        load      = 1'b0;
        execute   = 1'b0;
        ofifo_rd  = 1'b0;
        pmem_wen  = 1'b1;
        pmem_addr = '0;
        busy      = (state != IDLE);
        done      = 1'b0;

        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (start) begin
                    k_nxt     = '0;
                    state_nxt = W_FILL;
                end
            end
            W_FILL: begin
                xmem_addr = addr_w'(w_base) + addr_w'(k) * addr_w'(col) + addr_w'(cnt);
                if (l0_full) begin
                    cnt_nxt = cnt;
                end else begin
                    xmem_cen = 1'b0;
                    l0_wr    = 1'b1;
                    if (cnt == CNT_W'(col - 1)) state_nxt = W_LOAD;
                end
            end
            W_LOAD: begin
                // load trails l0_rd by one cycle because the corelet registers l0_rd
                l0_rd = (cnt < CNT_W'(col));
                load  = (cnt != '0);
                if (cnt == CNT_W'(col)) state_nxt = W_DRAIN;
            end
            W_DRAIN: begin
                if (cnt == CNT_W'(row + col - 1)) state_nxt = A_FILL;
            end
            A_FILL: begin
                xmem_addr = addr_w'(cnt);
                if (l0_full) begin
                    cnt_nxt = cnt;
                end else begin
                    xmem_cen = 1'b0;
                    l0_wr    = 1'b1;
                    if (cnt == CNT_W'(len_nij - 1)) state_nxt = EXEC;
                end
            end
            EXEC: begin
                l0_rd   = (cnt < CNT_W'(len_nij));
                execute = (cnt != '0);
                if (cnt == CNT_W'(len_nij)) state_nxt = E_DRAIN;
            end
            E_DRAIN: begin
                if (cnt == CNT_W'(row + col - 1)) state_nxt = READOUT;
            end
            READOUT: begin
                cnt_nxt   = '0;
                ofifo_rd  = ofifo_valid && (rd_cnt < NIJ_W'(len_nij));
                pmem_addr = addr_w'(k) * addr_w'(len_nij) + addr_w'(wr_cnt);
                if (pop_q) begin
                    pmem_wen = 1'b0;
                    if (wr_cnt == NIJ_W'(len_nij - 1)) begin
                        state_nxt = NEXT_K;
                        done      = (k == K_W'(kij - 1));
                    end
                end
            end
            NEXT_K: begin
                if (k == K_W'(kij - 1)) begin
                    state_nxt = IDLE;
                end else begin
                    k_nxt     = k + K_W'(1);
                    state_nxt = W_FILL;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (state_nxt != state) cnt_nxt = '0;
    end

endmodule

// File: tb/tb_corelet_ctrl.sv
// Directed bench for corelet_ctrl: reset values, fill/load ordering, L0 stall, gapped readout, abort, full run.
module tb_corelet_ctrl;
    localparam int ROW = 8;
    localparam int COL = 8;
    localparam int NIJ = 36;
    localparam int KIJ = 9;
    localparam int WB  = 128;
    localparam int AW  = 11;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          l0_full;
    logic          ofifo_valid;
    logic          xmem_cen;
    logic [AW-1:0] xmem_addr;
    logic          l0_wr;
    logic          l0_rd;
    logic          load;
    logic          execute;
    logic          ofifo_rd;
    logic          pmem_wen;
    logic [AW-1:0] pmem_addr;
    logic          busy;
    logic          done;

    corelet_ctrl #(
        .row(ROW), .col(COL), .len_nij(NIJ), .kij(KIJ), .w_base(WB), .addr_w(AW)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .l0_full(l0_full), .ofifo_valid(ofifo_valid),
        .xmem_cen(xmem_cen), .xmem_addr(xmem_addr), .l0_wr(l0_wr), .l0_rd(l0_rd),
        .load(load), .execute(execute), .ofifo_rd(ofifo_rd), .pmem_wen(pmem_wen),
        .pmem_addr(pmem_addr), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int   n_assert = 0;
    int   n_fail   = 0;
    int   kk, wcount, pcount, nload, nexec, nrd, npop, ndone, busy_cycles, nwrites, exp_addr;
    bit   finished, stalled;
    logic prev_rd, prev_pop;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_assert++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, want);
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_xmem_cen"},  xmem_cen,  1);
        chk({tag, "_xmem_addr"}, xmem_addr, 0);
        chk({tag, "_l0_wr"},     l0_wr,     0);
        chk({tag, "_l0_rd"},     l0_rd,     0);
        chk({tag, "_load"},      load,      0);
        chk({tag, "_execute"},   execute,   0);
        chk({tag, "_ofifo_rd"},  ofifo_rd,  0);
        chk({tag, "_pmem_wen"},  pmem_wen,  1);
        chk({tag, "_pmem_addr"}, pmem_addr, 0);
        chk({tag, "_busy"},      busy,      0);
        chk({tag, "_done"},      done,      0);
    endtask

    // Runs from a start pulse until busy falls, or until the first execute of abort_k (then asserts reset).
    task automatic do_run(input bit gapped, input bit do_stall, input int abort_k);
        kk = 0; wcount = 0; pcount = 0; nload = 0; nexec = 0; nrd = 0; npop = 0;
        ndone = 0; busy_cycles = 0; nwrites = 0; finished = 0; stalled = 0;
        prev_rd = 1'b0; prev_pop = 1'b0;
        @(negedge clk);
        start = 1'b1;
        #1;
        chk("idle_before_start", busy, 0);
        for (int cyc = 0; cyc < 4000 && !finished; cyc++) begin
            @(negedge clk);
            start       = (cyc == 300);
            l0_full     = 1'b0;
            ofifo_valid = gapped ? ((cyc % 2) == 0) : 1'b1;
            #1;
            if (do_stall && !stalled && kk == 0 && wcount == COL + 3 && l0_wr) begin
                stalled = 1;
                for (int s = 0; s < 5; s++) begin
                    l0_full = 1'b1;
                    #1;
                    chk("stall_l0_wr", l0_wr, 0);
                    chk("stall_cen", xmem_cen, 1);
                    chk("stall_addr", xmem_addr, 3);
                    @(negedge clk);
                end
                l0_full = 1'b0;
                #1;
            end
            if (abort_k >= 0 && kk == abort_k && execute) begin
                reset = 1'b0;
                #1;
                chk_reset_outs("abort");
                finished = 1;
            end else if (!busy) begin
                finished = 1;
            end else begin
                busy_cycles++;
                if (cyc == 0) begin
                    chk("first_l0_wr", l0_wr, 1);
                    chk("first_xmem_addr", xmem_addr, WB);
                end
                chk("cen_vs_wr", xmem_cen, !l0_wr);
                if (l0_wr) begin
                    exp_addr = (wcount < COL) ? WB + kk * COL + wcount : wcount - COL;
                    chk("xmem_addr", xmem_addr, exp_addr);
                    wcount++;
                end
                if (l0_rd) nrd++;
                if (load) begin
                    chk("load_after_rd", prev_rd, 1);
                    nload++;
                end
                if (execute) begin
                    chk("exec_after_rd", prev_rd, 1);
                    nexec++;
                end
                if (ofifo_rd) begin
                    chk("pop_needs_valid", ofifo_valid, 1);
                    npop++;
                end
                if (done) begin
                    ndone++;
                    chk("done_wen", pmem_wen, 0);
                    chk("done_addr", pmem_addr, KIJ * NIJ - 1);
                end
                if (!pmem_wen) begin
                    chk("wen_after_pop", prev_pop, 1);
                    chk("pmem_addr", pmem_addr, kk * NIJ + pcount);
                    pcount++;
                    nwrites++;
                    if (pcount == NIJ) begin
                        chk("k_l0_writes", wcount, COL + NIJ);
                        chk("k_loads", nload, COL);
                        chk("k_executes", nexec, NIJ);
                        chk("k_l0_reads", nrd, COL + NIJ);
                        chk("k_pops", npop, NIJ);
                        kk++;
                        wcount = 0; pcount = 0; nload = 0; nexec = 0; nrd = 0; npop = 0;
                    end
                end
                prev_rd  = l0_rd;
                prev_pop = ofifo_rd;
            end
        end
        chk("run_terminated", finished, 1);
    endtask

    initial begin
        reset       = 1'b0;
        start       = 1'b0;
        l0_full     = 1'b0;
        ofifo_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk_reset_outs("in_reset");
        reset = 1'b1;
        @(negedge clk);
        #1;
        chk_reset_outs("after_reset");
        ofifo_valid = 1'b1;
        l0_full     = 1'b1;
        #1;
        chk("idle_ofifo_rd", ofifo_rd, 0);
        chk("idle_l0_wr", l0_wr, 0);
        ofifo_valid = 1'b0;
        l0_full     = 1'b0;

        // Stalled fill, gapped readout, then abort during EXEC of k=4
        do_run(1'b1, 1'b1, 4);
        chk("abort_k", kk, 4);
        chk("abort_writes", nwrites, 4 * NIJ);
        chk("abort_no_done", ndone, 0);
        chk("stall_seen", stalled, 1);
        repeat (2) begin
            @(negedge clk);
            #1;
            chk_reset_outs("held_reset");
        end
        reset = 1'b1;

        // Full ideal run after the abort
        do_run(1'b0, 1'b0, -1);
        chk("full_writes", nwrites, KIJ * NIJ);
        chk("full_done_pulses", ndone, 1);
        chk("full_busy_cycles", busy_cycles, 1440);
        chk("full_k", kk, KIJ);
        #1;
        chk_reset_outs("end_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
